// File: rtl/neuron_mac_seq.sv
// Single-neuron multiply-accumulate sequencer: walks the shared weight/activation read address and produces one saturated Q-format output per START.
// Build option: define NEURON_MAC_RELU_EN to clamp negative outputs to zero before they are registered into Y.
module neuron_mac_seq #(
    parameter int N_IN      = 28,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] BIAS,
    input  logic [DATA_W-1:0] W_DO,
    input  logic [DATA_W-1:0] X_DO,
    output logic [ADDR_W-1:0] ADDR,
    output logic              EN,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] Y
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                     state;
    logic signed [DATA_W-1:0]   bias_q;
    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    scaled;

    function automatic logic signed [DATA_W-1:0] sat_y(input logic signed [ACC_W-1:0] v);
        if (v > Y_MAX)
            sat_y = Y_MAX[DATA_W-1:0];
        else if (v < Y_MIN)
            sat_y = Y_MIN[DATA_W-1:0];
        else
            sat_y = v[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] act_y(input logic signed [DATA_W-1:0] v);
`ifdef NEURON_MAC_RELU_EN
        act_y = v[DATA_W-1] ? '0 : v;
`else
        act_y = v;
`endif
    endfunction

    // Full-precision product, sign-extended so the accumulator never wraps over N_IN terms.
    assign prod     = $signed(W_DO) * $signed(X_DO);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    // Bias is aligned to the product's 2*FRAC_BITS binary point before the final rescale.
    assign bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
    assign sum      = acc + (bias_ext <<< FRAC_BITS);
    assign scaled   = sum >>> FRAC_BITS;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            ADDR   <= '0;
            EN     <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            Y      <= '0;
            acc    <= '0;
            bias_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        bias_q <= $signed(BIAS);
                        acc    <= '0;
                        ADDR   <= '0;
                        EN     <= 1'b1;
                        BUSY   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        EN <= 1'b0;
                    end
                end
                // Memory data for the address driven on the previous edge is consumed here.
                RUN: begin
                    acc <= acc + prod_ext;
                    if (ADDR == LAST_ADDR) begin
                        EN    <= 1'b0;
                        ADDR  <= '0;
                        state <= FINISH;
                    end else begin
                        ADDR <= ADDR + ADDR_W'(1);
                    end
                end
                FINISH: begin
                    Y     <= act_y(sat_y(scaled));
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench for neuron_mac_seq: a behavioural memory feeds W_DO/X_DO and a reference model predicts Y and DONE timing.
module tb_neuron_mac_seq;

    localparam int N_IN = 28;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] BIAS = '0;
    logic [15:0] W_DO = '0;
    logic [15:0] X_DO = '0;
    logic [4:0]  ADDR;
    logic        EN;
    logic        BUSY;
    logic        DONE;
    logic [15:0] Y;

    typedef struct {
        logic [15:0] y;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] wmem[N_IN];
    logic [15:0] xmem[N_IN];
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          en_idx = 0;
    int          done_cnt = 0;

    neuron_mac_seq dut (
        .CLK(CLK), .RST(RST), .START(START), .BIAS(BIAS), .W_DO(W_DO), .X_DO(X_DO),
        .ADDR(ADDR), .EN(EN), .BUSY(BUSY), .DONE(DONE), .Y(Y)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Both memories register DO on the falling edge after ADDR/EN are driven.
    always @(negedge CLK) begin
        if (EN) begin
            W_DO <= wmem[ADDR];
            X_DO <= xmem[ADDR];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] b);
        longint s;
        s = 0;
        for (int i = 0; i < N_IN; i++)
            s += longint'($signed(wmem[i])) * longint'($signed(xmem[i]));
        s += longint'($signed(b)) * 256;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`ifdef NEURON_MAC_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[15:0];
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            en_idx = 0;
        end else begin
            if (EN) begin
                check("addr_seq", ADDR, en_idx);
                en_idx++;
            end else if (en_idx != 0) begin
                check("en_length", en_idx, N_IN);
                en_idx = 0;
            end
            if (DONE) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("y", Y, e.y);
                    check("done_cycle", cyc, e.cyc);
                    check("busy_at_done", BUSY, 0);
                end
            end
        end
    end

    task automatic fill(input logic [15:0] w, input logic [15:0] x);
        for (int i = 0; i < N_IN; i++) begin
            wmem[i] = w;
            xmem[i] = x;
        end
    endtask

    // Call right after a falling edge; START is sampled on the following rising edge.
    task automatic start_op(input logic [15:0] b, input bit accept);
        exp_t e;
        START = 1'b1;
        BIAS  = b;
        if (accept) begin
            e.y   = model(b);
            e.cyc = cyc + N_IN + 2;
            sb.push_back(e);
        end
        @(negedge CLK);
        START = 1'b0;
        BIAS  = 16'h5A5A;
        if (accept) check("busy_after_start", BUSY, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (sb.size() == 0) break;
        end
        check("op_timeout", sb.size(), 0);
        @(negedge CLK);
    endtask

    task automatic run_op(input logic [15:0] b, input logic [15:0] y_const);
        @(negedge CLK);
        start_op(b, 1'b1);
        wait_idle();
        check("y_const", Y, y_const);
    endtask

    initial begin
        int seen;
        int dc;
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int seen;
        int dc;
        fill(16'h0000, 16'h0000);
        repeat (2) @(negedge CLK);
        check("rst_en", EN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_y", Y, 0);
        check("rst_addr", ADDR, 0);
        #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("idle_en", EN, 0);

        fill(16'h0100, 16'h0100);
        run_op(16'h0000, 16'h1C00);

        fill(16'hFF00, 16'h0100);
`ifdef NEURON_MAC_RELU_EN
        run_op(16'h0000, 16'h0000);
`else
        run_op(16'h0000, 16'hE400);
`endif

        fill(16'h7FFF, 16'h7FFF);
        run_op(16'h0000, 16'h7FFF);
        fill(16'h8000, 16'h7FFF);
`ifdef NEURON_MAC_RELU_EN
        run_op(16'h0000, 16'h0000);
`else
        run_op(16'h0000, 16'h8000);
`endif

        fill(16'h0000, 16'h0100);
        run_op(16'h0180, 16'h0180);
        fill(16'h0080, 16'h0100);
        run_op(16'hF200, 16'h0000);

        for (int k = 0; k < 3; k++) begin
            logic [15:0] rb;
            for (int i = 0; i < N_IN; i++) begin
                wmem[i] = 16'($urandom_range(0, 16'hFFFF));
                xmem[i] = 16'($urandom_range(0, 16'hFFFF));
            end
            rb = 16'($urandom_range(0, 16'hFFFF));
            @(negedge CLK);
            start_op(rb, 1'b1);
            wait_idle();
        end

        // START during an operation is ignored; then a START coincident with DONE.
        fill(16'h0100, 16'h0100);
        @(negedge CLK);
        start_op(16'h0000, 1'b1);
        repeat (8) @(negedge CLK);
        start_op(16'h7000, 1'b0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (DONE) begin
                seen = 1;
                break;
            end
        end
        check("b2b_first_done_seen", seen, 1);
        start_op(16'h0100, 1'b1);
        wait_idle();
        check("b2b_y", Y, 16'h1D00);

        // Asynchronous reset in the middle of an operation.
        fill(16'h0100, 16'h0100);
        @(negedge CLK);
        start_op(16'h0000, 1'b1);
        repeat (10) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("arst_en", EN, 0);
        check("arst_busy", BUSY, 0);
        check("arst_done", DONE, 0);
        check("arst_y", Y, 0);
        sb.delete();
        dc = done_cnt;
        repeat (2) @(negedge CLK);
        #1 RST = 1'b0;
        repeat (40) @(negedge CLK);
        check("no_done_after_rst", done_cnt, dc);
        check("idle_after_rst", BUSY, 0);

        run_op(16'h0000, 16'h1C00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
